// File: rtl/m16c5x_ssp_xfer_ctrl_if.sv
// SPI-master side of the SSP transfer controller.
//   we_cr / we_tf / re_rf : single-cycle CR write, TF write and RF read strobes
//   dout                  : byte to the SPI master DI input (0 when no strobe)
//   din                   : byte from the SPI master DO output
//   tf_ff / rf_ef         : TF full / RF empty flags
// The master modport is the controller; the slave modport is the SPI master.
interface m16c5x_ssp_xfer_ctrl_if;
    logic       we_cr;
    logic       we_tf;
    logic       re_rf;
    logic [7:0] dout;
    logic [7:0] din;
    logic       tf_ff;
    logic       rf_ef;

    modport master (
        output we_cr, we_tf, re_rf, dout,
        input  din, tf_ff, rf_ef
    );

    modport slave (
        input  we_cr, we_tf, re_rf, dout,
        output din, tf_ff, rf_ef
    );
endinterface

// File: rtl/m16c5x_ssp_xfer_ctrl.sv
// Transaction sequencer/arbiter in front of M16C5x_SPI. Two requesters issue 16-bit SSP frames
// ({RA[2:0], WnR, WD[11:0]}). Per frame, CR is rewritten when the target device changes, two bytes are
// pushed into TF, two bytes are popped from RF, and the 16-bit response is returned with an ack pulse.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   clk_en_i              : SPI interface clock enable; strobes only issue when high
//   req_i[1:0]            : level requests, held until the matching ack
//   ra*_i, wnr*_i, wd*_i  : frame fields per requester
//   ack_o[1:0]            : one-cycle completion pulse to the served requester
//   rd_o[15:0]            : response {RF byte0, RF byte1}, held until the next completed read
//   err_o                 : high on the ack cycle when the frame timed out
//   busy_o                : high when not idle
//   spi                   : SPI master strobes/data/flags
module m16c5x_ssp_xfer_ctrl #(
    parameter logic [7:0]  CrDev0 = 8'h0F,
    parameter logic [7:0]  CrDev1 = 8'h0E,
    parameter int unsigned ToW    = 12
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clk_en_i,
    input  logic [1:0]             req_i,
    input  logic [2:0]             ra0_i,
    input  logic [2:0]             ra1_i,
    input  logic                   wnr0_i,
    input  logic                   wnr1_i,
    input  logic [11:0]            wd0_i,
    input  logic [11:0]            wd1_i,
    output logic [1:0]             ack_o,
    output logic [15:0]            rd_o,
    output logic                   err_o,
    output logic                   busy_o,
    m16c5x_ssp_xfer_ctrl_if.master spi
);

    typedef enum logic [2:0] {
        StIdle, StGrant, StSetCr, StWrHi, StWrLo, StRdHi, StRdLo, StDone
    } state_e;

    state_e           state_q, state_d;
    logic             sel_q;
    logic             rr_last_q;
    logic             cr_vld_q;
    logic [7:0]       last_cr_q;
    logic [7:0]       hi_q, lo_q;
    logic [15:0]      rd_q;
    logic [ToW-1:0]   tocnt_q;

    logic             arb_sel;
    logic [7:0]       cr_sel;
    logic             in_rd;
    logic             timeout;
    logic             tf_ok, rf_ok;
    logic             we_cr, we_tf, re_rf;
    logic [7:0]       dout;

    // Tie goes to the requester not served last.
    assign arb_sel = (req_i == 2'b11) ? ~rr_last_q : req_i[1];
    assign cr_sel  = sel_q ? CrDev1 : CrDev0;
    assign in_rd   = (state_q == StRdHi) || (state_q == StRdLo);
    assign timeout = in_rd && (&tocnt_q);
    assign tf_ok   = clk_en_i && !spi.tf_ff;
    assign rf_ok   = clk_en_i && !spi.rf_ef;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (|req_i) state_d = StGrant;
            StGrant: state_d = (!cr_vld_q || (last_cr_q != cr_sel)) ? StSetCr : StWrHi;
            StSetCr: if (clk_en_i) state_d = StWrHi;
            StWrHi:  if (tf_ok) state_d = StWrLo;
            StWrLo:  if (tf_ok) state_d = StRdHi;
            StRdHi: begin
                if (timeout)    state_d = StIdle;
                else if (rf_ok) state_d = StRdLo;
            end
            StRdLo: begin
                if (timeout)    state_d = StIdle;
                else if (rf_ok) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs; strobes and ack are forced low while reset is asserted so a mid-frame
    // reset silences the SPI side in the same cycle.
    always_comb begin
        we_cr = 1'b0;
        we_tf = 1'b0;
        re_rf = 1'b0;
        dout  = 8'h00;
        ack_o = 2'b00;
        err_o = 1'b0;
        if (!rst_i) begin
            case (state_q)
                StSetCr: begin
                    if (clk_en_i) begin
                        we_cr = 1'b1;
                        dout  = cr_sel;
                    end
                end
                StWrHi: begin
                    if (tf_ok) begin
                        we_tf = 1'b1;
                        dout  = hi_q;
                    end
                end
                StWrLo: begin
                    if (tf_ok) begin
                        we_tf = 1'b1;
                        dout  = lo_q;
                    end
                end
                StRdHi, StRdLo: begin
                    if (timeout) begin
                        ack_o = sel_q ? 2'b10 : 2'b01;
                        err_o = 1'b1;
                    end else if (rf_ok) begin
                        re_rf = 1'b1;
                    end
                end
                StDone:  ack_o = sel_q ? 2'b10 : 2'b01;
                default: ;
            endcase
        end
    end

    assign busy_o    = (state_q != StIdle);
    assign rd_o      = rd_q;
    assign spi.we_cr = we_cr;
    assign spi.we_tf = we_tf;
    assign spi.re_rf = re_rf;
    assign spi.dout  = dout;

    // Frame datapath, CR tracking and response timeout
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_q     <= 1'b0;
            rr_last_q <= 1'b1;  // req0 has priority on the first tie after reset
            cr_vld_q  <= 1'b0;
            last_cr_q <= 8'h00;
            hi_q      <= 8'h00;
            lo_q      <= 8'h00;
            rd_q      <= 16'h0000;
            tocnt_q   <= '0;
        end else begin
            if ((state_q == StIdle) && (|req_i)) begin
                sel_q <= arb_sel;
            end
            if (state_q == StGrant) begin
                hi_q <= sel_q ? {ra1_i, wnr1_i, wd1_i[11:8]} : {ra0_i, wnr0_i, wd0_i[11:8]};
                lo_q <= sel_q ? wd1_i[7:0] : wd0_i[7:0];
            end
            if (we_cr) begin
                last_cr_q <= cr_sel;
                cr_vld_q  <= 1'b1;
            end
            if ((state_q == StWrLo && we_tf) || re_rf) begin
                tocnt_q <= '0;
            end else if (in_rd && !timeout && clk_en_i && spi.rf_ef) begin
                tocnt_q <= tocnt_q + 1'b1;
            end
            if (re_rf) begin
                if (state_q == StRdHi) rd_q[15:8] <= spi.din;
                else                   rd_q[7:0]  <= spi.din;
            end
            // A timed-out device may be in an unknown state; force a CR rewrite next frame.
            if (timeout) begin
                cr_vld_q <= 1'b0;
            end
            if (state_q == StDone) begin
                rr_last_q <= sel_q;
            end
        end
    end

endmodule

// File: tb/tb_m16c5x_ssp_xfer_ctrl.sv
// Directed bench for m16c5x_ssp_xfer_ctrl: CR programming, frame bytes, RF capture, round-robin
// arbitration, TF back-pressure, response timeout (ToW=4) and mid-frame reset.
module tb_m16c5x_ssp_xfer_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_en = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [2:0]  ra0 = 3'd0, ra1 = 3'd0;
    logic        wnr0 = 1'b0, wnr1 = 1'b0;
    logic [11:0] wd0 = 12'h0, wd1 = 12'h0;
    logic [1:0]  ack;
    logic [15:0] rd;
    logic        err, busy;
    int          checks = 0;
    int          failures = 0;

    m16c5x_ssp_xfer_ctrl_if spi_if ();

    m16c5x_ssp_xfer_ctrl #(
        .CrDev0 (8'h0F),
        .CrDev1 (8'h0E),
        .ToW    (4)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .clk_en_i (clk_en),
        .req_i    (req),
        .ra0_i    (ra0),
        .ra1_i    (ra1),
        .wnr0_i   (wnr0),
        .wnr1_i   (wnr1),
        .wd0_i    (wd0),
        .wd1_i    (wd1),
        .ack_o    (ack),
        .rd_o     (rd),
        .err_o    (err),
        .busy_o   (busy),
        .spi      (spi_if.master)
    );

    always #5 clk = ~clk;

    // ClkEn toggles every cycle
    initial begin
        forever begin
            @(posedge clk);
            #1 clk_en = ~clk_en;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for the next strobe and check its kind {we_cr,we_tf,re_rf}, DO and ClkEn.
    // After an RF read, present next_din for the following read.
    task automatic wait_strobe(input string tag, input logic [2:0] kind, input logic [7:0] exp_do,
                               input logic [7:0] next_din);
        int  n;
        logic seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (spi_if.we_cr || spi_if.we_tf || spi_if.re_rf) begin
                seen = 1'b1;
                chk({tag, "_kind"}, {29'd0, spi_if.we_cr, spi_if.we_tf, spi_if.re_rf}, {29'd0, kind});
                chk({tag, "_do"}, {24'd0, spi_if.dout}, {24'd0, exp_do});
                chk({tag, "_clken"}, {31'd0, clk_en}, 32'd1);
            end
        end
        if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
        if (seen && kind == 3'b001) begin
            @(posedge clk);
            #1 spi_if.din = next_din;
        end
    endtask

    task automatic wait_ack(input string tag, input logic [1:0] exp_ack, input logic exp_err,
                            input logic [15:0] exp_rd, input logic drop);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack === 2'b00 && n < 200);
        chk({tag, "_ack"}, {30'd0, ack}, {30'd0, exp_ack});
        chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        chk({tag, "_rd"}, {16'd0, rd}, {16'd0, exp_rd});
        if (drop) req = 2'b00;
    endtask

    task automatic frame(input string tag, input int who, input logic do_cr, input logic [7:0] cr,
                         input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] b0,
                         input logic [7:0] b1, input logic drop);
        spi_if.din = b0;
        req[who] = 1'b1;
        if (do_cr) wait_strobe({tag, "_cr"}, 3'b100, cr, 8'h00);
        wait_strobe({tag, "_hi"}, 3'b010, hi, 8'h00);
        wait_strobe({tag, "_lo"}, 3'b010, lo, 8'h00);
        wait_strobe({tag, "_rdhi"}, 3'b001, 8'h00, b1);
        wait_strobe({tag, "_rdlo"}, 3'b001, 8'h00, b1);
        wait_ack(tag, (who == 0) ? 2'b01 : 2'b10, 1'b0, {b0, b1}, drop);
    endtask

    initial begin
        int n;
        int n_en;
        int n_st;
        spi_if.din   = 8'h00;
        spi_if.tf_ff = 1'b0;
        spi_if.rf_ef = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ack", {30'd0, ack}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_rd", {16'd0, rd}, 32'd0);
        chk("rst_strobes", {29'd0, spi_if.we_cr, spi_if.we_tf, spi_if.re_rf}, 32'd0);
        chk("rst_do", {24'd0, spi_if.dout}, 32'd0);

        // 1: first frame programs CR; hi = {000,1,0010}
        ra0 = 3'd0; wnr0 = 1'b1; wd0 = 12'h200;
        frame("t1", 0, 1'b1, 8'h0F, 8'h12, 8'h00, 8'hA5, 8'h5A, 1'b1);

        // 2: same device, no CR write; hi = {001,0,0000}
        ra0 = 3'd1; wnr0 = 1'b0; wd0 = 12'h000;
        frame("t2", 0, 1'b0, 8'h00, 8'h20, 8'h00, 8'h3C, 8'hC3, 1'b1);

        // 3: both requesting, alternating grants starting with requester 1
        ra1 = 3'd5; wnr1 = 1'b1; wd1 = 12'hABC;  // hi = 8'hBA
        ra0 = 3'd2; wnr0 = 1'b0; wd0 = 12'h345;  // hi = 8'h43
        req = 2'b11;
        frame("t3a", 1, 1'b1, 8'h0E, 8'hBA, 8'hBC, 8'h11, 8'h81, 1'b0);
        frame("t3b", 0, 1'b1, 8'h0F, 8'h43, 8'h45, 8'h12, 8'h82, 1'b0);
        frame("t3c", 1, 1'b1, 8'h0E, 8'hBA, 8'hBC, 8'h13, 8'h83, 1'b0);
        frame("t3d", 0, 1'b1, 8'h0F, 8'h43, 8'h45, 8'h14, 8'h84, 1'b1);

        // 4: TF full stalls WRHI; hi = {110,1,1111}
        spi_if.tf_ff = 1'b1;
        ra0 = 3'd6; wnr0 = 1'b1; wd0 = 12'hF0F;
        spi_if.din = 8'h12;
        req[0] = 1'b1;
        n_st = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (spi_if.we_cr || spi_if.we_tf || spi_if.re_rf) n_st++;
        end
        chk("t4_no_strobe_full", n_st, 0);
        chk("t4_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1 spi_if.tf_ff = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (clk_en !== 1'b1 && n < 4);
        chk("t4_first_tf", {31'd0, spi_if.we_tf}, 32'd1);
        chk("t4_first_do", {24'd0, spi_if.dout}, 32'hDF);
        wait_strobe("t4_lo", 3'b010, 8'h0F, 8'h00);
        wait_strobe("t4_rdhi", 3'b001, 8'h00, 8'h34);
        wait_strobe("t4_rdlo", 3'b001, 8'h00, 8'h34);
        wait_ack("t4", 2'b01, 1'b0, 16'h1234, 1'b1);

        // 5: RF stays empty -> timeout after 15 ClkEn cycles; hi = {011,0,0111}
        spi_if.rf_ef = 1'b1;
        ra0 = 3'd3; wnr0 = 1'b0; wd0 = 12'h789;
        req[0] = 1'b1;
        wait_strobe("t5_hi", 3'b010, 8'h67, 8'h00);
        wait_strobe("t5_lo", 3'b010, 8'h89, 8'h00);
        n = 0; n_en = 0; n_st = 0;
        do begin
            @(negedge clk);
            n++;
            if (ack === 2'b00) begin
                if (clk_en) n_en++;
                if (spi_if.re_rf) n_st++;
            end
        end while (ack === 2'b00 && n < 200);
        chk("t5_to_cycles", n_en, 15);
        chk("t5_no_rerf", n_st, 0);
        chk("t5_ack", {30'd0, ack}, 32'd1);
        chk("t5_err", {31'd0, err}, 32'd1);
        chk("t5_rd_held", {16'd0, rd}, 32'h1234);
        req = 2'b00;
        @(posedge clk);
        #1 spi_if.rf_ef = 1'b0;
        frame("t5b", 0, 1'b1, 8'h0F, 8'h67, 8'h89, 8'h9A, 8'hBC, 1'b1);

        // 6: reset while waiting in RDHI; hi = {001,1,0100}
        spi_if.rf_ef = 1'b1;
        ra0 = 3'd1; wnr0 = 1'b1; wd0 = 12'h456;
        req[0] = 1'b1;
        wait_strobe("t6_hi", 3'b010, 8'h34, 8'h00);
        wait_strobe("t6_lo", 3'b010, 8'h56, 8'h00);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_strobes", {29'd0, spi_if.we_cr, spi_if.we_tf, spi_if.re_rf}, 32'd0);
        chk("t6_ack", {30'd0, ack}, 32'd0);
        chk("t6_rd", {16'd0, rd}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        spi_if.rf_ef = 1'b0;
        frame("t6b", 0, 1'b1, 8'h0F, 8'h34, 8'h56, 8'h77, 8'h88, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end
endmodule
